// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, and fills the IF/ID register.
// A RUN/HALT/FAULT state machine handles halt words, out-of-range fetches and redirects.
module instruction_fetch_unit #(
  parameter int          MEM_BYTES = 60,
  parameter logic [15:0] HALT_WORD = 16'hEFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] instrAddress,
  input  logic [15:0] instrData,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  output logic [15:0] ifidInstr,
  output logic [15:0] ifidPC,
  output logic [15:0] ifidPCPlus2,
  output logic        ifidValid,
  output logic        halted,
  output logic        addrFault,
  output logic [15:0] fetchCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [15:0] MEM_LIMIT = 16'(MEM_BYTES);

  state_t      r_state;
  logic [15:0] r_pc_p0;
  logic [15:0] r_instr_p1;
  logic [15:0] r_pc_p1;
  logic [15:0] r_pc_plus2_p1;
  logic        r_vld_p1;
  logic        r_halted;
  logic        r_fault;
  logic [15:0] r_count;

  logic        w_in_range;
  logic        w_is_halt;
  logic [15:0] w_pc_next;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    sat_inc = (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign w_in_range = (r_pc_p0 < MEM_LIMIT);
  assign w_is_halt  = (instrData == HALT_WORD);
  assign w_pc_next  = r_pc_p0 + 16'd2;

  // Stage boundary: PC (p0) -> IF/ID register (p1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc_p0       <= 16'd0;
      r_instr_p1    <= 16'd0;
      r_pc_p1       <= 16'd0;
      r_pc_plus2_p1 <= 16'd0;
      r_vld_p1      <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_count       <= 16'd0;
    end else if (branchTaken) begin
      // Halt/fault came from the wrong path, so a redirect clears them.
      r_pc_p0    <= {branchTarget[15:1], 1'b0};
      r_instr_p1 <= 16'd0;
      r_vld_p1   <= 1'b0;
      r_state    <= RUN;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        RUN: begin
          if (w_in_range) begin
            r_instr_p1    <= instrData;
            r_pc_p1       <= r_pc_p0;
            r_pc_plus2_p1 <= w_pc_next;
            r_vld_p1      <= 1'b1;
            r_count       <= sat_inc(r_count);
            if (w_is_halt) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc_p0 <= w_pc_next;
            end
          end else begin
            r_vld_p1 <= 1'b0;
            r_state  <= FAULT;
            r_fault  <= 1'b1;
          end
        end
        default: begin
          r_vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign instrAddress = r_pc_p0;
  assign ifidInstr    = r_instr_p1;
  assign ifidPC       = r_pc_p1;
  assign ifidPCPlus2  = r_pc_plus2_p1;
  assign ifidValid    = r_vld_p1;
  assign halted       = r_halted;
  assign addrFault    = r_fault;
  assign fetchCount   = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a small 30-word program image.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] instrAddress;
  logic [15:0] instrData;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPC;
  logic [15:0] ifidPCPlus2;
  logic        ifidValid;
  logic        halted;
  logic        addrFault;
  logic [15:0] fetchCount;

  logic [15:0] mem [0:31];
  int compares;
  int mismatches;

  instruction_fetch_unit #(.MEM_BYTES(60), .HALT_WORD(16'hEFFF)) dut (
    .clk(clk), .reset(reset), .instrAddress(instrAddress), .instrData(instrData),
    .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .ifidInstr(ifidInstr), .ifidPC(ifidPC), .ifidPCPlus2(ifidPCPlus2),
    .ifidValid(ifidValid), .halted(halted), .addrFault(addrFault), .fetchCount(fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    instrData = 16'h0000;
    if (instrAddress < 16'd60) instrData = mem[instrAddress[5:1]];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = 16'h0;
    step(2);
    compares++; if (instrAddress !== 16'h0) begin mismatches++; $display("FAIL rst_addr got %h want 0000", instrAddress); end
    compares++; if (ifidInstr !== 16'h0) begin mismatches++; $display("FAIL rst_instr got %h want 0000", ifidInstr); end
    compares++; if (ifidValid !== 1'b0) begin mismatches++; $display("FAIL rst_valid got %b want 0", ifidValid); end
    compares++; if (halted !== 1'b0 || addrFault !== 1'b0) begin mismatches++; $display("FAIL rst_flags got %b%b want 00", halted, addrFault); end
    compares++; if (fetchCount !== 16'h0) begin mismatches++; $display("FAIL rst_count got %h want 0000", fetchCount); end
    reset = 1'b0;
  endtask

  task automatic test_free_run;
    step(1);
    compares++; if (ifidInstr !== 16'h0120) begin mismatches++; $display("FAIL run1_instr got %h want 0120", ifidInstr); end
    compares++; if (ifidPC !== 16'h0) begin mismatches++; $display("FAIL run1_pc got %h want 0000", ifidPC); end
    compares++; if (instrAddress !== 16'h2) begin mismatches++; $display("FAIL run1_addr got %h want 0002", instrAddress); end
    compares++; if (ifidValid !== 1'b1 || fetchCount !== 16'd1) begin mismatches++; $display("FAIL run1_vc got %b/%0d want 1/1", ifidValid, fetchCount); end
    step(1);
    compares++; if (ifidInstr !== 16'h0121) begin mismatches++; $display("FAIL run2_instr got %h want 0121", ifidInstr); end
    compares++; if (ifidPC !== 16'h2 || ifidPCPlus2 !== 16'h4) begin mismatches++; $display("FAIL run2_pc got %h/%h want 0002/0004", ifidPC, ifidPCPlus2); end
  endtask

  task automatic test_halt;
    step(24);
    compares++; if (halted !== 1'b1) begin mismatches++; $display("FAIL halt_flag got %b want 1", halted); end
    compares++; if (ifidInstr !== 16'hEFFF || ifidValid !== 1'b1) begin mismatches++; $display("FAIL halt_instr got %h/%b want efff/1", ifidInstr, ifidValid); end
    compares++; if (ifidPC !== 16'd50 || instrAddress !== 16'd50) begin mismatches++; $display("FAIL halt_pc got %0d/%0d want 50/50", ifidPC, instrAddress); end
    compares++; if (fetchCount !== 16'd26) begin mismatches++; $display("FAIL halt_count got %0d want 26", fetchCount); end
    step(1);
    compares++; if (ifidValid !== 1'b0) begin mismatches++; $display("FAIL halt_bubble got %b want 0", ifidValid); end
    compares++; if (fetchCount !== 16'd26 || instrAddress !== 16'd50 || halted !== 1'b1) begin mismatches++; $display("FAIL halt_hold got %0d/%0d/%b want 26/50/1", fetchCount, instrAddress, halted); end
  endtask

  task automatic test_reset_while_halted;
    reset = 1'b1; stall = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0030;
    step(1);
    compares++; if (instrAddress !== 16'h0 || ifidInstr !== 16'h0 || ifidPC !== 16'h0 || ifidPCPlus2 !== 16'h0) begin mismatches++; $display("FAIL rsth_data got %h/%h/%h/%h want 0", instrAddress, ifidInstr, ifidPC, ifidPCPlus2); end
    compares++; if (ifidValid !== 1'b0 || halted !== 1'b0 || addrFault !== 1'b0 || fetchCount !== 16'h0) begin mismatches++; $display("FAIL rsth_ctrl got %b%b%b/%0d want 000/0", ifidValid, halted, addrFault, fetchCount); end
    reset = 1'b0; stall = 1'b0; branchTaken = 1'b0;
  endtask

  task automatic test_stall;
    step(4);
    compares++; if (instrAddress !== 16'd8 || ifidInstr !== 16'h0001) begin mismatches++; $display("FAIL pre_stall got %0d/%h want 8/0001", instrAddress, ifidInstr); end
    stall = 1'b1;
    step(3);
    compares++; if (instrAddress !== 16'd8) begin mismatches++; $display("FAIL stall_addr got %0d want 8", instrAddress); end
    compares++; if (ifidInstr !== 16'h0001 || ifidPC !== 16'd6 || ifidValid !== 1'b1) begin mismatches++; $display("FAIL stall_ifid got %h/%0d/%b want 0001/6/1", ifidInstr, ifidPC, ifidValid); end
    compares++; if (fetchCount !== 16'd4) begin mismatches++; $display("FAIL stall_count got %0d want 4", fetchCount); end
    stall = 1'b0;
    step(1);
    compares++; if (ifidInstr !== 16'h0448 || ifidPC !== 16'd8 || fetchCount !== 16'd5) begin mismatches++; $display("FAIL stall_rel got %h/%0d/%0d want 0448/8/5", ifidInstr, ifidPC, fetchCount); end
  endtask

  task automatic test_branch_stall;
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0015;
    step(1);
    stall = 1'b0; branchTaken = 1'b0;
    compares++; if (instrAddress !== 16'h0014) begin mismatches++; $display("FAIL br_addr got %h want 0014", instrAddress); end
    compares++; if (ifidValid !== 1'b0 || ifidInstr !== 16'h0 || fetchCount !== 16'd5) begin mismatches++; $display("FAIL br_flush got %b/%h/%0d want 0/0000/5", ifidValid, ifidInstr, fetchCount); end
    step(1);
    compares++; if (ifidInstr !== 16'h0B10 || ifidPC !== 16'h0014 || ifidValid !== 1'b1) begin mismatches++; $display("FAIL br_target got %h/%h/%b want 0b10/0014/1", ifidInstr, ifidPC, ifidValid); end
  endtask

  task automatic test_fault;
    branchTaken = 1'b1; branchTarget = 16'h0040;
    step(1);
    branchTaken = 1'b0;
    compares++; if (instrAddress !== 16'd64 || ifidValid !== 1'b0 || addrFault !== 1'b0) begin mismatches++; $display("FAIL flt_br got %0d/%b/%b want 64/0/0", instrAddress, ifidValid, addrFault); end
    step(1);
    compares++; if (addrFault !== 1'b1 || ifidValid !== 1'b0 || instrAddress !== 16'd64) begin mismatches++; $display("FAIL flt_set got %b/%b/%0d want 1/0/64", addrFault, ifidValid, instrAddress); end
    compares++; if (fetchCount !== 16'd6) begin mismatches++; $display("FAIL flt_count got %0d want 6", fetchCount); end
    step(2);
    compares++; if (addrFault !== 1'b1 || instrAddress !== 16'd64) begin mismatches++; $display("FAIL flt_hold got %b/%0d want 1/64", addrFault, instrAddress); end
    branchTaken = 1'b1; branchTarget = 16'h0000;
    step(1);
    branchTaken = 1'b0;
    compares++; if (addrFault !== 1'b0 || instrAddress !== 16'h0) begin mismatches++; $display("FAIL flt_clr got %b/%h want 0/0000", addrFault, instrAddress); end
    step(1);
    compares++; if (ifidInstr !== 16'h0120 || ifidValid !== 1'b1 || fetchCount !== 16'd7) begin mismatches++; $display("FAIL flt_resume got %h/%b/%0d want 0120/1/7", ifidInstr, ifidValid, fetchCount); end
  endtask

  initial begin
    compares = 0;
    mismatches = 0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h0120;
    mem[1]  = 16'h0121;
    mem[3]  = 16'h0001;
    mem[4]  = 16'h0448;
    mem[10] = 16'h0B10;
    mem[25] = 16'hEFFF;
    test_reset();
    test_free_run();
    test_halt();
    test_reset_while_halted();
    test_stall();
    test_branch_stall();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the 16-bit datapath: owns the program counter, drives the byte address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register with its PC. Handles decode-stage stalls, branch/jump redirects from downstream with wrong-path flush, halt detection, and out-of-range fetch faults. Sits directly upstream of instruction memory (address side) and feeds the decode stage.

## Interface
- MEM_BYTES, 60: instruction memory size in bytes (30 words × 2); a fetch address ≥ this value is a fault.
- HALT_WORD, 16'hEFFF: instruction encoding that halts fetch.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instrAddress  output  16  byte address to instruction memory, equals PC register (combinational from register).
- instrData  input  16  instruction word returned combinationally by memory for instrAddress.
- stall  input  1  decode requests hold: PC and IF/ID unchanged.
- branchTaken  input  1  redirect request from downstream, one-cycle pulse.
- branchTarget  input  16  redirect byte address; bit 0 forced to 0.
- ifidInstr  output  16  latched instruction.
- ifidPC  output  16  byte address of ifidInstr.
- ifidPCPlus2  output  16  ifidPC + 2, mod 2^16.
- ifidValid  output  1  IF/ID holds a real instruction.
- halted  output  1  high in HALT state.
- addrFault  output  1  high in FAULT state.
- fetchCount  output  16  count of instructions latched with valid=1, saturates at 16'hFFFF.

## Operation
- States: RUN, HALT, FAULT. Reset → RUN.
- Reset (highest priority): PC=0, ifidInstr=0, ifidPC=0, ifidPCPlus2=0, ifidValid=0, halted=0, addrFault=0, fetchCount=0.
- Priority each cycle: reset > branchTaken > stall > normal fetch.
- branchTaken (any state): PC ← {branchTarget[15:1],1'b0}; ifidInstr ← 0, ifidValid ← 0 (flush); state ← RUN (clears halt/fault, since they came from wrong path). fetchCount unchanged.
- stall (RUN, no branch): all registers hold, including ifidValid.
- RUN, no stall, PC < MEM_BYTES: ifidInstr ← instrData, ifidPC ← PC, ifidPCPlus2 ← PC+2, ifidValid ← 1, fetchCount += 1 (saturating). If instrData == HALT_WORD: PC holds, state ← HALT; else PC ← PC+2 (wraps at 16 bits).
- RUN, no stall, PC ≥ MEM_BYTES: no capture; ifidValid ← 0; PC holds; state ← FAULT.
- HALT / FAULT: PC holds; ifidValid ← 0 on next non-stalled edge (halt instruction is delivered once); stall still holds IF/ID. Exit only via branchTaken or reset.
- halted = (state==HALT), addrFault = (state==FAULT); both registered.

## Timing
- Fetch latency: instruction at address A appears on ifidInstr one edge after instrAddress = A.
- Sustained throughput: one instruction per cycle when stall=0.
- Redirect penalty: branch edge issues bubble (ifidValid=0); target instruction latched on following edge → one bubble cycle.
- Branch with stall same cycle: branch wins, flush occurs.
- reset asserted mid-stream: all state cleared at that edge regardless of other inputs; first fetch of address 0 on first edge with reset=0.
- HALT_WORD fetched: ifidValid=1 with HALT_WORD for exactly one non-stalled cycle, halted rises on same edge.

## Test plan
- Reset then free-run over standard program: edge 1 → ifidInstr=0x0120, ifidPC=0, instrAddress=2; edge 2 → 0x0121, ifidPC=2, ifidPCPlus2=4.
- Run to halt (word 25 = 0xEFFF at byte 50): after 26 edges halted=1, ifidInstr=0xEFFF, ifidPC=50, instrAddress=50, fetchCount=26; next edge ifidValid=0, count stays 26.
- Stall 3 cycles at PC=8: instrAddress stays 8, ifidInstr=0x0001 (from PC=6) held, fetchCount frozen; release → 0x0448 latched.
- branchTaken with target 0x0015 while stall=1 at PC=10: next edge instrAddress=0x0014, ifidValid=0; following edge ifidInstr=0x0B10, ifidPC=0x14.
- branchTaken to 0x0040: next edge instrAddress=64, ifidValid=0; next edge addrFault=1; branch to 0 → addrFault=0, then 0x0120 fetched.
- reset asserted while halted with fetchCount=26: next edge all outputs 0, state RUN.
